// File: rtl/multicycle_control.sv
// multicycle_control
//   Sequencing FSM for the multi-cycle RV64-subset core. It drives the
//   strobes and mux selects of a datapath that has one shared instruction
//   and data memory plus IR, oldPC, A/B and ALUOut registers. It also
//   handles the memory ready handshake, a memory-wait timeout, the halt on
//   an illegal opcode, and the cycle and retired-instruction counters.
//
// Ports
//   clk, reset        core clock, asynchronous active-low reset
//   opcode            IR[6:0]
//   mem_ready         shared memory completes its access this cycle
//   pcWrite/pcWriteCond/iorD/memRead/memWrite/irWrite/memToReg/regWrite
//                     datapath strobes (combinational from state)
//   aluOp/aluSrcA/aluSrcB/pcSource
//                     datapath selects (combinational from state)
//   state, halted     debug view of the FSM
//   err_timeout, err_illegal
//                     sticky error flags, cleared only by reset
//   cycle_count, instret
//                     free-running counters, wrap modulo 2^CNT_W
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pcWrite,
  output logic             pcWriteCond,
  output logic             iorD,
  output logic             memRead,
  output logic             memWrite,
  output logic             irWrite,
  output logic             memToReg,
  output logic             regWrite,
  output logic [1:0]       aluOp,
  output logic [1:0]       aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic             pcSource,
  output logic [3:0]       state,
  output logic             halted,
  output logic             err_timeout,
  output logic             err_illegal,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_HALT     = 4'd9
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // The wait count reaches MEM_TIMEOUT on the cycle it would step from
  // MEM_TIMEOUT-1; a missing ready on that cycle halts the core.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [7:0]         wait_q, wait_d;
  logic               err_to_q, err_to_d;
  logic               err_il_q, err_il_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   ret_q, ret_d;

  // Ungated decode of the current state
  logic       s_pcw, s_pcwc, s_iord, s_mrd, s_mwr, s_irw, s_m2r, s_rw, s_pcs;
  logic [1:0] s_aop, s_sa, s_sb;
  logic       in_mem;

  always_comb begin
    state_d  = state_q;
    wait_d   = 8'd0;
    err_to_d = err_to_q;
    err_il_d = err_il_q;
    cyc_d    = cyc_q;
    ret_d    = ret_q;
    s_pcw  = 1'b0; s_pcwc = 1'b0; s_iord = 1'b0; s_mrd = 1'b0;
    s_mwr  = 1'b0; s_irw  = 1'b0; s_m2r  = 1'b0; s_rw  = 1'b0;
    s_pcs  = 1'b0; s_aop  = 2'b00; s_sa  = 2'b00; s_sb  = 2'b00;
    in_mem = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        in_mem = 1'b1;
        s_mrd  = 1'b1;
        s_sb   = 2'b01;
        if (mem_ready) begin
          s_irw   = 1'b1;
          s_pcw   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target (oldPC + imm<<1) is parked in ALUOut here
        s_sa = 2'b01;
        s_sb = 2'b11;
        unique case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_RTYPE, OP_ITYPE: state_d = S_EXEC;
          OP_BRANCH:          state_d = S_BRANCH;
          default: begin
            state_d  = S_HALT;
            err_il_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        s_sa    = 2'b10;
        s_sb    = 2'b10;
        state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        in_mem = 1'b1;
        s_mrd  = 1'b1;
        s_iord = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        s_rw    = 1'b1;
        s_m2r   = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_WR: begin
        in_mem = 1'b1;
        s_mwr  = 1'b1;
        s_iord = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        s_sa = 2'b10;
        if (opcode == OP_RTYPE) begin
          s_sb  = 2'b00;
          s_aop = 2'b10;
        end else begin
          s_sb  = 2'b10;
          s_aop = 2'b11;
        end
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        s_rw    = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        s_sa    = 2'b10;
        s_aop   = 2'b01;
        s_pcwc  = 1'b1;
        s_pcs   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    // Wait counter: only counts stalled memory cycles; ready wins over
    // the timeout on the same cycle.
    if (in_mem && !mem_ready) begin
      if (wait_q == WAIT_LAST) begin
        state_d  = S_HALT;
        err_to_d = 1'b1;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end

    if (state_q != S_HALT) cyc_d = cyc_q + 1'b1;

    if (state_d == S_FETCH &&
        (state_q == S_MEM_WB || state_q == S_MEM_WR ||
         state_q == S_ALU_WB || state_q == S_BRANCH))
      ret_d = ret_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      wait_q   <= 8'd0;
      err_to_q <= 1'b0;
      err_il_q <= 1'b0;
      cyc_q    <= '0;
      ret_q    <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      err_to_q <= err_to_d;
      err_il_q <= err_il_d;
      cyc_q    <= cyc_d;
      ret_q    <= ret_d;
    end
  end

  // Gating with reset drops every strobe the instant reset falls, before
  // the state register has had an edge to settle.
  assign pcWrite     = reset & s_pcw;
  assign pcWriteCond = reset & s_pcwc;
  assign iorD        = reset & s_iord;
  assign memRead     = reset & s_mrd;
  assign memWrite    = reset & s_mwr;
  assign irWrite     = reset & s_irw;
  assign memToReg    = reset & s_m2r;
  assign regWrite    = reset & s_rw;
  assign pcSource    = reset & s_pcs;
  assign aluOp       = reset ? s_aop : 2'b00;
  assign aluSrcA     = reset ? s_sa  : 2'b00;
  assign aluSrcB     = reset ? s_sb  : 2'b00;

  assign state       = state_q;
  assign halted      = (state_q == S_HALT);
  assign err_timeout = err_to_q;
  assign err_illegal = err_il_q;
  assign cycle_count = cyc_q;
  assign instret     = ret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus a
// randomized instruction stream checked against a per-instruction state
// sequence model.
module tb_multicycle_control;

  localparam int TO = 15;
  localparam int CW = 32;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [6:0]    opcode = '0;
  logic          mem_ready = 1'b0;
  logic          pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic          memToReg, regWrite, pcSource, halted, err_timeout, err_illegal;
  logic [1:0]    aluOp, aluSrcA, aluSrcB;
  logic [3:0]    state;
  logic [CW-1:0] cycle_count, instret;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .memToReg(memToReg), .regWrite(regWrite), .aluOp(aluOp),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcSource(pcSource),
    .state(state), .halted(halted), .err_timeout(err_timeout),
    .err_illegal(err_illegal), .cycle_count(cycle_count), .instret(instret)
  );

  always #5 clk = ~clk;

  // All strobes and selects as one vector, in a fixed field order
  wire [14:0] sb = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
                    memToReg, regWrite, aluOp, aluSrcA, aluSrcB, pcSource};

  function automatic logic [14:0] mk(bit pcw, bit pcwc, bit iord, bit mr,
                                     bit mw, bit irw, bit m2r, bit rw,
                                     logic [1:0] aop, logic [1:0] sa,
                                     logic [1:0] sbb, bit pcs);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rw, aop, sa, sbb, pcs};
  endfunction

  // Reset for one full cycle; returns at a falling edge with reset released
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    n_tests++;
    if (state !== 4'd0 || cycle_count !== '0 || instret !== '0 ||
        err_timeout !== 1'b0 || err_illegal !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d cyc=%0d ret=%0d eto=%b eil=%b hlt=%b, want 0/0/0/0/0/0",
               state, cycle_count, instret, err_timeout, err_illegal, halted);
    end
    n_tests++;
    if (sb !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want all zero", sb);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_rtype();
    int seq[5] = '{0, 1, 6, 7, 0};
    int rw_cnt = 0;
    logic [14:0] e;
    do_reset();
    opcode = OP_R;
    for (int c = 0; c < 5; c++) begin
      mem_ready = 1'b1;
      #1;
      n_tests++;
      if (state !== 4'(seq[c])) begin
        n_fail++;
        $display("FAIL rtype_state c%0d: got %0d want %0d", c, state, seq[c]);
      end
      if (regWrite === 1'b1) rw_cnt++;
      e = 'x;
      case (c)
        0: e = mk(1,0,0,1,0,1,0,0,2'b00,2'b00,2'b01,0);
        1: e = mk(0,0,0,0,0,0,0,0,2'b00,2'b01,2'b11,0);
        2: e = mk(0,0,0,0,0,0,0,0,2'b10,2'b10,2'b00,0);
        3: e = mk(0,0,0,0,0,0,0,1,2'b00,2'b00,2'b00,0);
        default: ;
      endcase
      if (c < 4) begin
        n_tests++;
        if (sb !== e) begin
          n_fail++;
          $display("FAIL rtype_strobes c%0d: got %b want %b", c, sb, e);
        end
      end else begin
        n_tests++;
        if (cycle_count !== 32'd4 || instret !== 32'd1) begin
          n_fail++;
          $display("FAIL rtype_counters: cyc=%0d ret=%0d want 4/1", cycle_count, instret);
        end
      end
      @(negedge clk);
    end
    n_tests++;
    if (rw_cnt != 1) begin
      n_fail++;
      $display("FAIL rtype_regwrite_cycles: got %0d want 1", rw_cnt);
    end
  endtask

  task automatic test_load();
    int seq[9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    bit rdy[9] = '{1, 0, 0, 0, 0, 0, 1, 0, 1};
    int hold = 0;
    do_reset();
    opcode = OP_LD;
    for (int c = 0; c < 9; c++) begin
      mem_ready = rdy[c];
      #1;
      n_tests++;
      if (state !== 4'(seq[c])) begin
        n_fail++;
        $display("FAIL load_state c%0d: got %0d want %0d", c, state, seq[c]);
      end
      if (memRead === 1'b1 && iorD === 1'b1) hold++;
      if (c == 2) begin
        n_tests++;
        if (sb !== mk(0,0,0,0,0,0,0,0,2'b00,2'b10,2'b10,0)) begin
          n_fail++;
          $display("FAIL load_memaddr_strobes: got %b", sb);
        end
      end
      if (c == 7) begin
        n_tests++;
        if (sb !== mk(0,0,0,0,0,0,1,1,2'b00,2'b00,2'b00,0)) begin
          n_fail++;
          $display("FAIL load_wb_strobes: got %b", sb);
        end
      end
      if (c == 8) begin
        n_tests++;
        if (cycle_count !== 32'd8 || instret !== 32'd1) begin
          n_fail++;
          $display("FAIL load_counters: cyc=%0d ret=%0d want 8/1", cycle_count, instret);
        end
      end
      @(negedge clk);
    end
    n_tests++;
    if (hold != 4) begin
      n_fail++;
      $display("FAIL load_read_hold: got %0d cycles want 4", hold);
    end
  endtask

  // nz stalled cycles in MEM_WR; with nz == TO the core must time out,
  // with fewer the access completes on the next cycle.
  task automatic test_timeout(input int nz);
    bit expect_halt = (nz >= TO);
    do_reset();
    opcode = OP_ST;
    for (int c = 0; c < 3; c++) begin
      mem_ready = (c == 0);
      #1;
      @(negedge clk);
    end
    for (int c = 0; c < nz; c++) begin
      mem_ready = 1'b0;
      #1;
      n_tests++;
      if (state !== 4'd5 || memWrite !== 1'b1 || iorD !== 1'b1) begin
        n_fail++;
        $display("FAIL timeout_wait%0d w%0d: state=%0d mw=%b iord=%b want 5/1/1",
                 nz, c, state, memWrite, iorD);
      end
      @(negedge clk);
    end
    if (expect_halt) begin
      for (int k = 0; k < 3; k++) begin
        mem_ready = 1'b0;
        #1;
        n_tests++;
        if (state !== 4'd9 || halted !== 1'b1 || err_timeout !== 1'b1 ||
            memWrite !== 1'b0 || cycle_count !== 32'(3 + nz)) begin
          n_fail++;
          $display("FAIL timeout_halt k%0d: st=%0d hlt=%b eto=%b mw=%b cyc=%0d want 9/1/1/0/%0d",
                   k, state, halted, err_timeout, memWrite, cycle_count, 3 + nz);
        end
        @(negedge clk);
      end
    end else begin
      mem_ready = 1'b1;
      #1;
      n_tests++;
      if (state !== 4'd5 || memWrite !== 1'b1) begin
        n_fail++;
        $display("FAIL timeout_lastcycle: state=%0d mw=%b want 5/1", state, memWrite);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (state !== 4'd0 || err_timeout !== 1'b0 || instret !== 32'd1 ||
          cycle_count !== 32'(4 + nz)) begin
        n_fail++;
        $display("FAIL timeout_complete: st=%0d eto=%b ret=%0d cyc=%0d want 0/0/1/%0d",
                 state, err_timeout, instret, cycle_count, 4 + nz);
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    opcode = OP_BR;
    mem_ready = 1'b1;
    #1;
    @(negedge clk);
    #1;
    n_tests++;
    if (state !== 4'd1 || sb !== mk(0,0,0,0,0,0,0,0,2'b00,2'b01,2'b11,0)) begin
      n_fail++;
      $display("FAIL branch_decode: state=%0d strobes=%b", state, sb);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (state !== 4'd8 || sb !== mk(0,1,0,0,0,0,0,0,2'b01,2'b10,2'b00,1)) begin
      n_fail++;
      $display("FAIL branch_exec: state=%0d strobes=%b", state, sb);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (state !== 4'd0 || instret !== 32'd1) begin
      n_fail++;
      $display("FAIL branch_retire: state=%0d ret=%0d want 0/1", state, instret);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = OP_BAD;
    mem_ready = 1'b1;
    #1;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      #1;
      n_tests++;
      if (state !== 4'd9 || halted !== 1'b1 || err_illegal !== 1'b1 ||
          err_timeout !== 1'b0 || cycle_count !== 32'd2 || sb !== 15'd0) begin
        n_fail++;
        $display("FAIL illegal_halt k%0d: st=%0d hlt=%b eil=%b eto=%b cyc=%0d sb=%b",
                 k, state, halted, err_illegal, err_timeout, cycle_count, sb);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (state !== 4'd0 || halted !== 1'b0 || err_illegal !== 1'b0 ||
        cycle_count !== '0 || instret !== '0) begin
      n_fail++;
      $display("FAIL illegal_reset_clear: st=%0d hlt=%b eil=%b cyc=%0d ret=%0d",
               state, halted, err_illegal, cycle_count, instret);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset_midwrite();
    do_reset();
    opcode = OP_ST;
    for (int c = 0; c < 3; c++) begin
      mem_ready = (c == 0);
      #1;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    #1;
    n_tests++;
    if (memWrite !== 1'b1) begin
      n_fail++;
      $display("FAIL midwrite_pre: mw=%b want 1", memWrite);
    end
    #1;
    reset = 1'b0;
    #1;
    n_tests++;
    if (memWrite !== 1'b0 || iorD !== 1'b0 || state !== 4'd0) begin
      n_fail++;
      $display("FAIL midwrite_async_drop: mw=%b iord=%b st=%0d want 0/0/0",
               memWrite, iorD, state);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Random instruction stream: each instruction expands into the state
  // sequence it must walk, with random memory stalls (below the timeout).
  task automatic test_random();
    int sq[$];
    bit rq[$];
    logic [6:0] ops[5] = '{OP_LD, OP_ST, OP_R, OP_I, OP_BR};
    int exp_cyc = 0;
    int exp_ret = 0;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      int cls = $urandom_range(0, 4);
      int df  = $urandom_range(0, 4);
      int dm  = $urandom_range(0, 4);
      sq.delete();
      rq.delete();
      for (int i = 0; i < df; i++) begin sq.push_back(0); rq.push_back(0); end
      sq.push_back(0); rq.push_back(1);
      sq.push_back(1); rq.push_back(1'($urandom_range(0, 1)));
      case (cls)
        0: begin
          sq.push_back(2); rq.push_back(1'($urandom_range(0, 1)));
          for (int i = 0; i < dm; i++) begin sq.push_back(3); rq.push_back(0); end
          sq.push_back(3); rq.push_back(1);
          sq.push_back(4); rq.push_back(1'($urandom_range(0, 1)));
        end
        1: begin
          sq.push_back(2); rq.push_back(1'($urandom_range(0, 1)));
          for (int i = 0; i < dm; i++) begin sq.push_back(5); rq.push_back(0); end
          sq.push_back(5); rq.push_back(1);
        end
        2, 3: begin
          sq.push_back(6); rq.push_back(1'($urandom_range(0, 1)));
          sq.push_back(7); rq.push_back(1'($urandom_range(0, 1)));
        end
        default: begin
          sq.push_back(8); rq.push_back(1'($urandom_range(0, 1)));
        end
      endcase
      opcode = ops[cls];
      for (int i = 0; i < sq.size(); i++) begin
        int s = sq[i];
        mem_ready = rq[i];
        #1;
        n_tests++;
        if (state !== 4'(s) || memRead !== (s == 0 || s == 3) ||
            memWrite !== (s == 5) || regWrite !== (s == 4 || s == 7) ||
            iorD !== (s == 3 || s == 5)) begin
          n_fail++;
          $display("FAIL random i%0d c%0d: st=%0d mr=%b mw=%b rw=%b iord=%b want st=%0d",
                   n, i, state, memRead, memWrite, regWrite, iorD, s);
        end
        exp_cyc++;
        @(negedge clk);
      end
      exp_ret++;
      #1;
      n_tests++;
      if (state !== 4'd0 || cycle_count !== 32'(exp_cyc) || instret !== 32'(exp_ret)) begin
        n_fail++;
        $display("FAIL random_counters i%0d: st=%0d cyc=%0d ret=%0d want 0/%0d/%0d",
                 n, state, cycle_count, instret, exp_cyc, exp_ret);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load();
    test_timeout(TO);
    test_timeout(TO - 1);
    test_branch();
    test_illegal();
    test_reset_midwrite();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Sequencing FSM for the multi-cycle variant of the 64-bit RV-subset core.
- Replaces the single-cycle combinational control unit.
- Drives the strobes and mux selects of a datapath with one shared instruction/data memory, IR, oldPC, A/B and ALUOut registers.
- Also handles the shared-memory ready handshake, memory timeout, illegal-opcode halt, and cycle/retired-instruction counters.

Parameters:
- MEM_TIMEOUT, 15: max consecutive wait cycles with mem_ready=0 in any memory state before halting; range 1..255.
- CNT_W, 32: width of the cycle and instret counters.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- opcode  in  7  IR[6:0]
- mem_ready  in  1  memory access completes this cycle
- pcWrite  out  1  PC load, unconditional
- pcWriteCond  out  1  PC load if ALU zero
- iorD  out  1  memory address select: 0=PC, 1=ALUOut
- memRead  out  1  memory read request
- memWrite  out  1  memory write request
- irWrite  out  1  IR and oldPC load
- memToReg  out  1  write-back select: 0=ALUOut, 1=MDR
- regWrite  out  1  register file write
- aluOp  out  2  00 add, 01 branch/sub, 10 R-type funct7/funct3, 11 I-type funct3
- aluSrcA  out  2  00 PC, 01 oldPC, 10 rs1 (A)
- aluSrcB  out  2  00 B, 01 const 4, 10 imm, 11 imm<<1
- pcSource  out  1  0=ALU result, 1=ALUOut
- state  out  4  current state, debug
- halted  out  1  in HALT
- err_timeout  out  1  sticky memory-timeout flag
- err_illegal  out  1  sticky illegal-opcode flag
- cycle_count  out  CNT_W  cycles executed while not halted
- instret  out  CNT_W  retired instructions

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, ALU_WB=7, BRANCH=8, HALT=9. State is registered; strobes are combinational from state (and mem_ready where noted).
- Reset (reset=0, async): state=FETCH, both counters=0, err flags=0, wait counter=0. While reset is low, every strobe is 0 regardless of state.
- Default for every strobe not listed below: 0; default for every select: 00/0.
- FETCH: memRead=1, iorD=0, aluSrcA=00, aluSrcB=01, aluOp=00.
  - If mem_ready=1: irWrite=1 and pcWrite=1 in that same cycle; next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: aluSrcA=01, aluSrcB=11, aluOp=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEM_ADDR
  - 0110011 or 0010011 -> EXEC
  - 1100011 -> BRANCH
  - anything else -> HALT with err_illegal set
- MEM_ADDR: aluSrcA=10, aluSrcB=10, aluOp=00. Next MEM_RD for a load, MEM_WR for a store; the opcode is re-read from IR, which is stable.
- MEM_RD: memRead=1, iorD=1. On mem_ready go to MEM_WB; otherwise stay.
- MEM_WB: regWrite=1, memToReg=1; go to FETCH; instret increments.
- MEM_WR: memWrite=1, iorD=1. On mem_ready go to FETCH and instret increments; otherwise stay. memWrite stays asserted until ready.
- EXEC: aluSrcA=10. aluSrcB=00 and aluOp=10 for R-type; aluSrcB=10 and aluOp=11 for I-type. Go to ALU_WB.
- ALU_WB: regWrite=1, memToReg=0; go to FETCH; instret increments.
- BRANCH: aluSrcA=10, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=1; go to FETCH; instret increments.
- HALT: all strobes 0; halted=1; the only exit is reset.
- Memory handshake: iorD and the request strobe are held constant from entry to a memory state until the mem_ready cycle. mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- Timeout: the wait counter increments each memory-state cycle with mem_ready=0 and clears on mem_ready or on leaving the state.
  - When it reaches MEM_TIMEOUT, the next state is HALT and err_timeout=1.
  - mem_ready=1 in the cycle the count equals MEM_TIMEOUT wins: the access completes and no error is raised.
- Counters:
  - cycle_count increments every clock while state!=HALT.
  - instret increments on each transition into FETCH from MEM_WB, MEM_WR, ALU_WB or BRANCH.
  - Both wrap modulo 2^CNT_W without any flag.
- Reset asserted mid-instruction aborts the instruction immediately. No partial-write strobe may be emitted after reset falls.

Test Plan:
- R-type add with mem_ready tied 1 -> states 0,1,6,7,0; regWrite high exactly 1 cycle; instret=1 after 4 cycles; cycle_count=4.
- Load with mem_ready delayed 3 cycles in MEM_RD -> memRead and iorD=1 held 4 cycles; MEM_WB asserts regWrite with memToReg=1; total 8 cycles; instret=1.
- Store with mem_ready=0 for 15 cycles in MEM_WR (MEM_TIMEOUT=15) -> HALT, err_timeout=1, memWrite=0 thereafter, cycle_count frozen. Repeat with mem_ready on cycle 15 -> completes, no error.
- beq opcode 1100011 -> DECODE drives aluSrcA=01/aluSrcB=11; BRANCH drives pcWriteCond=1, pcSource=1, aluOp=01; instret increments.
- Opcode 1111111 -> HALT from DECODE, err_illegal=1, halted=1; then reset low for 1 cycle -> state=0, flags=0, counters=0.
- Reset pulled low while in MEM_WR with memWrite=1 -> memWrite drops asynchronously, before the next clock edge.
